// File: rtl/ov7670_dvp_tx.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_dvp_tx
// Description : OV7670-style DVP source. Produces PCLK (clk/2), VSYNC, HREF
//               and D[7:0] with the sensor's frame/line timing. Pixels come
//               from a valid/ready RGB565 stream or from an internal 8-bar
//               colour pattern.
// Ports       : clk, rst          - system clock, synchronous active-high reset
//               enable            - run frames (checked at frame boundaries)
//               pattern_en        - 1 = colour bars, 0 = stream (per frame)
//               pix_data/valid    - RGB565 stream input, [15:8] sent first
//               pix_ready         - stream pixel consumed this cycle if valid
//               pclk_o/vsync_o/href_o/d_o - DVP bus
//               frame_start       - one-clk pulse as vsync_o rises
//               frame_cnt         - completed frames (wrapping)
//               underflow         - sticky, a stream pixel was missing
//               busy              - a frame is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_dvp_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_ACTIVE = 480,
    parameter int VS_LINES = 3,
    parameter int VB_LINES = 17,
    parameter int VF_LINES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pattern_en,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        pclk_o,
    output logic        vsync_o,
    output logic        href_o,
    output logic [7:0]  d_o,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        underflow,
    output logic        busy
);

    localparam int c_LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam int c_MAX_LINES_A = (V_ACTIVE > VS_LINES) ? V_ACTIVE : VS_LINES;
    localparam int c_MAX_LINES_B = (VB_LINES > VF_LINES) ? VB_LINES : VF_LINES;
    localparam int c_MAX_LINES = (c_MAX_LINES_A > c_MAX_LINES_B) ? c_MAX_LINES_A : c_MAX_LINES_B;
    localparam int c_BW = $clog2(c_LINE_BYTES + 1);
    localparam int c_LW = $clog2(c_MAX_LINES + 1);

    localparam logic [c_BW-1:0] c_BYTE_LAST = c_BW'(c_LINE_BYTES - 1);
    localparam logic [c_BW-1:0] c_ACT_END   = c_BW'(2 * H_ACTIVE);
    localparam logic [c_BW-1:0] c_BAR_W     = c_BW'(H_ACTIVE / 8);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_VSYNC  = 3'd1;
    localparam logic [2:0] c_VBACK  = 3'd2;
    localparam logic [2:0] c_ACTIVE = 3'd3;
    localparam logic [2:0] c_VFRONT = 3'd4;

    logic [2:0]      r_state;
    logic            r_phase;
    logic [c_BW-1:0] r_byte;
    logic [c_LW-1:0] r_line;
    logic            r_pattern;
    logic            r_vsync;
    logic            r_href;
    logic [7:0]      r_d;
    logic [7:0]      r_lo;
    logic            r_pix_ready;
    logic            r_frame_start;
    logic [15:0]     r_frame_cnt;
    logic            r_underflow;

    logic [2:0]      w_nstate;
    logic [c_BW-1:0] w_nbyte;
    logic [c_LW-1:0] w_nline;
    logic [c_LW-1:0] w_last_line;
    logic            w_frame_begin;
    logic            w_frame_end;
    logic            w_href_n;
    logic            w_load_hi;
    logic [2:0]      w_bar;
    logic [15:0]     w_colour;
    logic [15:0]     w_pixel;

    // Position of the byte period that starts at the next pclk falling edge.
    // Everything shown on the bus is derived from this look-ahead so the
    // outputs register together with the counters.
    always_comb begin
        w_nstate    = r_state;
        w_nbyte     = r_byte;
        w_nline     = r_line;
        w_last_line = '0;
        case (r_state)
            c_VSYNC:  w_last_line = c_LW'(VS_LINES - 1);
            c_VBACK:  w_last_line = c_LW'(VB_LINES - 1);
            c_ACTIVE: w_last_line = c_LW'(V_ACTIVE - 1);
            c_VFRONT: w_last_line = c_LW'(VF_LINES - 1);
            default:  w_last_line = '0;
        endcase

        if (r_state == c_IDLE) begin
            w_nbyte = '0;
            w_nline = '0;
            if (enable) w_nstate = c_VSYNC;
        end else if (r_byte == c_BYTE_LAST) begin
            w_nbyte = '0;
            if (r_line == w_last_line) begin
                w_nline = '0;
                case (r_state)
                    c_VSYNC:  w_nstate = c_VBACK;
                    c_VBACK:  w_nstate = c_ACTIVE;
                    c_ACTIVE: w_nstate = c_VFRONT;
                    c_VFRONT: w_nstate = enable ? c_VSYNC : c_IDLE;
                    default:  w_nstate = c_IDLE;
                endcase
            end else begin
                w_nline = r_line + 1'b1;
            end
        end else begin
            w_nbyte = r_byte + 1'b1;
        end

        w_frame_begin = (w_nstate == c_VSYNC) && (r_state != c_VSYNC);
        w_frame_end   = (r_state == c_VFRONT) && (w_nstate != c_VFRONT);
        w_href_n      = (w_nstate == c_ACTIVE) && (w_nbyte < c_ACT_END);
        w_load_hi     = w_href_n && !w_nbyte[0];

        w_bar = 3'((w_nbyte >> 1) / c_BAR_W);
        case (w_bar)
            3'd0:    w_colour = 16'hFFFF;
            3'd1:    w_colour = 16'hFFE0;
            3'd2:    w_colour = 16'h07FF;
            3'd3:    w_colour = 16'h07E0;
            3'd4:    w_colour = 16'hF81F;
            3'd5:    w_colour = 16'hF800;
            3'd6:    w_colour = 16'h001F;
            default: w_colour = 16'h0000;
        endcase

        // A missing stream pixel is replaced by black.
        w_pixel = r_pattern ? w_colour : (pix_valid ? pix_data : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_phase       <= 1'b0;
            r_byte        <= '0;
            r_line        <= '0;
            r_pattern     <= 1'b0;
            r_vsync       <= 1'b0;
            r_href        <= 1'b0;
            r_d           <= 8'h00;
            r_lo          <= 8'h00;
            r_pix_ready   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 16'h0000;
            r_underflow   <= 1'b0;
        end else begin
            r_phase       <= ~r_phase;
            r_frame_start <= 1'b0;
            // Ready occupies the pclk-high cycle right before a high-byte load,
            // so the pixel is taken on the same edge that puts its MSB out.
            r_pix_ready   <= ~r_phase & w_load_hi & ~r_pattern;

            if (r_phase) begin
                r_state <= w_nstate;
                r_byte  <= w_nbyte;
                r_line  <= w_nline;
                r_vsync <= (w_nstate == c_VSYNC);
                r_href  <= w_href_n;
                if (w_frame_begin) begin
                    r_pattern     <= pattern_en;
                    r_frame_start <= 1'b1;
                end
                if (w_frame_end) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
                if (w_load_hi) begin
                    r_d  <= w_pixel[15:8];
                    r_lo <= w_pixel[7:0];
                    if (!r_pattern && !pix_valid) r_underflow <= 1'b1;
                end else if (w_href_n) begin
                    r_d <= r_lo;
                end else begin
                    r_d <= 8'h00;
                end
            end
        end
    end

    assign pclk_o      = r_phase;
    assign vsync_o     = r_vsync;
    assign href_o      = r_href;
    assign d_o         = r_d;
    assign pix_ready   = r_pix_ready;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;
    assign underflow   = r_underflow;
    assign busy        = (r_state != c_IDLE);

endmodule
`default_nettype wire
